// File: rtl/pixel_region_latency_buffer_if.sv
// Pixel-region bus: hit input, trigger, configuration and column readout.
// The master side drives hits, triggers, configuration, token-in and acknowledge.
// The slave side is the region buffer.
interface pixel_region_latency_buffer_if #(
  parameter int MEM_DEPTH = 8,
  parameter int NPIX      = 4,
  parameter int TOT_W     = 4,
  parameter int LAT_W     = 9,
  parameter int TAG_W     = 5,
  parameter int OVF_W     = 8
);
  logic                    LE;
  logic [NPIX*TOT_W-1:0]   HitTot;
  logic                    L1;
  logic [TAG_W-1:0]        L1Tag;
  logic [LAT_W-1:0]        LatCnfg;
  logic                    PixOffCnfg;
  logic                    TokIn;
  logic                    TokOut;
  logic                    ReadData;
  logic                    EnOut;
  logic [NPIX*TOT_W-1:0]   ReadTot;
  logic [TAG_W-1:0]        ReadTag;
  logic [MEM_DEPTH-1:0]    LeAddr;
  logic                    Full;
  logic [OVF_W-1:0]        OverflowCnt;

  modport master (
    output LE, HitTot, L1, L1Tag, LatCnfg, PixOffCnfg, TokIn, ReadData,
    input  TokOut, EnOut, ReadTot, ReadTag, LeAddr, Full, OverflowCnt
  );

  modport slave (
    input  LE, HitTot, L1, L1Tag, LatCnfg, PixOffCnfg, TokIn, ReadData,
    output TokOut, EnOut, ReadTot, ReadTag, LeAddr, Full, OverflowCnt
  );
endinterface

// File: rtl/pixel_region_latency_buffer.sv
// Pixel-region latency buffer: hits wait out a per-cell latency and survive
// only if L1 coincides with expiry. Triggered cells drain one per cycle
// through the column token chain.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CELL_FREE | cell empty, eligible for the next write
// CELL_WAIT | hit stored, latency counter running down
// CELL_TRIG | hit accepted by L1, tagged, waiting for column readout
module pixel_region_latency_buffer #(
  parameter int MEM_DEPTH = 8,
  parameter int NPIX      = 4,
  parameter int TOT_W     = 4,
  parameter int LAT_W     = 9,
  parameter int TAG_W     = 5,
  parameter int OVF_W     = 8
) (
  input  logic Clk,
  input  logic Reset,
  pixel_region_latency_buffer_if.slave bus
);
  localparam int DW = NPIX * TOT_W;

  typedef enum logic [1:0] {
    CELL_FREE = 2'd0,
    CELL_WAIT = 2'd1,
    CELL_TRIG = 2'd2
  } cell_state_t;

  cell_state_t          state_q [MEM_DEPTH];
  logic [LAT_W-1:0]     cnt_q   [MEM_DEPTH];
  logic [DW-1:0]        tot_q   [MEM_DEPTH];
  logic [TAG_W-1:0]     tag_q   [MEM_DEPTH];
  logic [OVF_W-1:0]     ovf_q;

  logic [MEM_DEPTH-1:0] free_vec;
  logic [MEM_DEPTH-1:0] trig_vec;
  logic [MEM_DEPTH-1:0] free_first;
  logic [MEM_DEPTH-1:0] trig_first;
  logic                 hit_valid;
  logic                 do_write;
  logic                 ready_any;
  logic                 en_out;
  logic                 do_pop;
  logic                 full;
  logic [DW-1:0]        read_tot;
  logic [TAG_W-1:0]     read_tag;

  // Occupancy vectors and lowest-index pickers; everything here uses pre-edge state
  // so a cell freed on an edge only becomes writable on the following edge.
  always_comb begin
    free_vec = '0;
    trig_vec = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      free_vec[i] = (state_q[i] == CELL_FREE);
      trig_vec[i] = (state_q[i] == CELL_TRIG);
    end
    free_first = free_vec & (~free_vec + MEM_DEPTH'(1));
    trig_first = trig_vec & (~trig_vec + MEM_DEPTH'(1));
    full       = ~(|free_vec);
    hit_valid  = bus.LE & (|bus.HitTot) & ~bus.PixOffCnfg;
    do_write   = hit_valid & ~full;
    ready_any  = |trig_vec;
    en_out     = ~bus.TokIn & ready_any & ~bus.PixOffCnfg;
    do_pop     = en_out & bus.ReadData;
  end

  // Read mux: present the lowest triggered cell, zeros when not driving the bus.
  always_comb begin
    read_tot = '0;
    read_tag = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (en_out && trig_first[i]) begin
        read_tot = tot_q[i];
        read_tag = tag_q[i];
      end
    end
  end

  // Per-cell state machines: write capture, latency countdown, trigger and readout.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        state_q[i] <= CELL_FREE;
        cnt_q[i]   <= '0;
        tot_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        case (state_q[i])
          CELL_FREE: begin
            if (do_write && free_first[i]) begin
              state_q[i] <= CELL_WAIT;
              cnt_q[i]   <= bus.LatCnfg;
              tot_q[i]   <= bus.HitTot;
            end
          end
          CELL_WAIT: begin
            if (cnt_q[i] != '0) begin
              cnt_q[i] <= cnt_q[i] - 1'b1;
            end else if (bus.L1) begin
              state_q[i] <= CELL_TRIG;
              tag_q[i]   <= bus.L1Tag;
            end else begin
              state_q[i] <= CELL_FREE;
            end
          end
          CELL_TRIG: begin
            // Masking flushes every triggered cell; otherwise only the presented one pops.
            if (bus.PixOffCnfg || (do_pop && trig_first[i])) begin
              state_q[i] <= CELL_FREE;
            end
          end
          default: state_q[i] <= CELL_FREE;
        endcase
      end
    end
  end

  // Saturating count of hits lost because every cell was occupied.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_q <= '0;
    end else if (hit_valid && full && (ovf_q != '1)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

  assign bus.TokOut      = bus.TokIn | (ready_any & ~bus.PixOffCnfg);
  assign bus.EnOut       = en_out;
  assign bus.ReadTot     = read_tot;
  assign bus.ReadTag     = read_tag;
  assign bus.LeAddr      = bus.PixOffCnfg ? '0 : free_first;
  assign bus.Full        = full;
  assign bus.OverflowCnt = ovf_q;
endmodule

// File: tb/tb_pixel_region_latency_buffer.sv
// Directed bench for the pixel-region latency buffer: a vector table for the
// basic trigger/readout flow plus hand-written multi-cycle sequences.
module tb_pixel_region_latency_buffer;
  localparam int MEM_DEPTH = 8;
  localparam int NPIX      = 4;
  localparam int TOT_W     = 4;
  localparam int LAT_W     = 9;
  localparam int TAG_W     = 5;
  localparam int OVF_W     = 8;

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  pixel_region_latency_buffer_if #(
    .MEM_DEPTH(MEM_DEPTH), .NPIX(NPIX), .TOT_W(TOT_W),
    .LAT_W(LAT_W), .TAG_W(TAG_W), .OVF_W(OVF_W)
  ) bus ();

  pixel_region_latency_buffer #(
    .MEM_DEPTH(MEM_DEPTH), .NPIX(NPIX), .TOT_W(TOT_W),
    .LAT_W(LAT_W), .TAG_W(TAG_W), .OVF_W(OVF_W)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        le;
    logic [15:0] hit;
    logic        l1;
    logic [4:0]  tag;
    logic        rd;
    logic        en;
    logic        tok;
    logic [15:0] tot;
    logic [4:0]  rtag;
    logic [7:0]  addr;
    logic        full;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic le, input logic [15:0] hit, input logic l1,
                              input logic [4:0] tag, input logic rd, input logic en,
                              input logic tok, input logic [15:0] tot, input logic [4:0] rtag,
                              input logic [7:0] addr, input logic full);
    vec_t v;
    v.le = le; v.hit = hit; v.l1 = l1; v.tag = tag; v.rd = rd;
    v.en = en; v.tok = tok; v.tot = tot; v.rtag = rtag; v.addr = addr; v.full = full;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.LE = 1'b0; bus.HitTot = '0; bus.L1 = 1'b0; bus.L1Tag = '0;
    bus.ReadData = 1'b0; bus.TokIn = 1'b0; bus.PixOffCnfg = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic write_hit(input logic [15:0] tot, input logic [8:0] lat);
    bus.LE = 1'b1; bus.HitTot = tot; bus.LatCnfg = lat;
  endtask

  // L1 arrives one edge early or late: the hit must be discarded.
  task automatic late_trigger(input int l1_edge);
    do_reset();
    write_hit(16'h1234, 9'd10);
    next_cyc();
    for (int k = 1; k <= 13; k++) begin
      idle_inputs();
      bus.L1 = (k == l1_edge); bus.L1Tag = 5'd7;
      #1;
      chk($sformatf("mistimed_l1_%0d_en_k%0d", l1_edge, k), 32'(bus.EnOut), 32'd0);
      if (k == 11) chk($sformatf("mistimed_l1_%0d_held", l1_edge), 32'(bus.LeAddr), 32'h02);
      if (k == 12) chk($sformatf("mistimed_l1_%0d_freed", l1_edge), 32'(bus.LeAddr), 32'h01);
      next_cyc();
    end
  endtask

  initial begin
    vecs[0] = mk(1, 16'h1234, 0, 0, 0, 0, 0, 16'h0, 0, 8'h01, 0);
    for (int i = 1; i <= 10; i++) vecs[i] = mk(0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 8'h02, 0);
    vecs[11] = mk(0, 16'h0, 1, 7, 0, 0, 0, 16'h0, 0, 8'h02, 0);
    vecs[12] = mk(0, 16'h0, 0, 0, 1, 1, 1, 16'h1234, 7, 8'h02, 0);
    vecs[13] = mk(0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 8'h01, 0);

    // Reset state
    Reset = 1'b1;
    idle_inputs();
    bus.LatCnfg = 9'd10;
    #1;
    chk("rst_en", 32'(bus.EnOut), 32'd0);
    chk("rst_tok", 32'(bus.TokOut), 32'd0);
    chk("rst_addr", 32'(bus.LeAddr), 32'h01);
    chk("rst_full", 32'(bus.Full), 32'd0);
    chk("rst_ovf", 32'(bus.OverflowCnt), 32'd0);
    bus.TokIn = 1'b1;
    #1;
    chk("rst_tok_pass", 32'(bus.TokOut), 32'd1);
    bus.PixOffCnfg = 1'b1;
    #1;
    chk("rst_addr_masked", 32'(bus.LeAddr), 32'h00);
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b0;

    // Basic flow from the vector table: latency 10, L1 on the 11th edge, then read.
    for (int i = 0; i < 14; i++) begin
      bus.LE = vecs[i].le; bus.HitTot = vecs[i].hit; bus.L1 = vecs[i].l1;
      bus.L1Tag = vecs[i].tag; bus.ReadData = vecs[i].rd; bus.TokIn = 1'b0;
      bus.PixOffCnfg = 1'b0;
      #1;
      chk($sformatf("vec%0d_en", i), 32'(bus.EnOut), 32'(vecs[i].en));
      chk($sformatf("vec%0d_tok", i), 32'(bus.TokOut), 32'(vecs[i].tok));
      chk($sformatf("vec%0d_tot", i), 32'(bus.ReadTot), 32'(vecs[i].tot));
      chk($sformatf("vec%0d_tag", i), 32'(bus.ReadTag), 32'(vecs[i].rtag));
      chk($sformatf("vec%0d_addr", i), 32'(bus.LeAddr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_full", i), 32'(bus.Full), 32'(vecs[i].full));
      next_cyc();
    end

    late_trigger(10);
    late_trigger(12);

    // Overflow: 10 writes into 8 cells, then let every counter expire.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      write_hit(16'(i + 1), 9'd20);
      #1;
      if (i == 8) begin
        chk("ovf_full_after8", 32'(bus.Full), 32'd1);
        chk("ovf_addr_after8", 32'(bus.LeAddr), 32'h00);
        chk("ovf_cnt_after8", 32'(bus.OverflowCnt), 32'd0);
      end
      next_cyc();
    end
    idle_inputs();
    #1;
    chk("ovf_cnt", 32'(bus.OverflowCnt), 32'd2);
    chk("ovf_full", 32'(bus.Full), 32'd1);
    for (int k = 10; k < 35; k++) begin
      idle_inputs();
      #1;
      if (k == 21) chk("ovf_full_before_expiry", 32'(bus.Full), 32'd1);
      if (k == 22) begin
        chk("ovf_full_after_expiry", 32'(bus.Full), 32'd0);
        chk("ovf_addr_after_expiry", 32'(bus.LeAddr), 32'h01);
      end
      next_cyc();
    end
    #1;
    chk("ovf_drained_full", 32'(bus.Full), 32'd0);
    chk("ovf_drained_addr", 32'(bus.LeAddr), 32'h01);
    chk("ovf_cnt_kept", 32'(bus.OverflowCnt), 32'd2);
    #1;
    Reset = 1'b1;
    #1;
    chk("ovf_async_reset", 32'(bus.OverflowCnt), 32'd0);
    Reset = 1'b0;

    // Three cells expire on one edge, token held upstream, then ordered drain.
    do_reset();
    write_hit(16'h0111, 9'd4); next_cyc();
    write_hit(16'h0222, 9'd3); next_cyc();
    write_hit(16'h0333, 9'd2); next_cyc();
    idle_inputs(); next_cyc();
    next_cyc();
    bus.L1 = 1'b1; bus.L1Tag = 5'd9; next_cyc();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      bus.TokIn = 1'b1; bus.ReadData = 1'b1;
      #1;
      chk($sformatf("tokin_hold_en%0d", k), 32'(bus.EnOut), 32'd0);
      chk($sformatf("tokin_hold_tok%0d", k), 32'(bus.TokOut), 32'd1);
      next_cyc();
    end
    for (int k = 0; k < 3; k++) begin
      logic [15:0] exp_tot;
      exp_tot = 16'h0111 * 16'(k + 1);
      bus.TokIn = 1'b0; bus.ReadData = 1'b1;
      #1;
      chk($sformatf("drain%0d_en", k), 32'(bus.EnOut), 32'd1);
      chk($sformatf("drain%0d_tot", k), 32'(bus.ReadTot), 32'(exp_tot));
      chk($sformatf("drain%0d_tag", k), 32'(bus.ReadTag), 32'd9);
      chk($sformatf("drain%0d_tok", k), 32'(bus.TokOut), 32'd1);
      next_cyc();
    end
    idle_inputs();
    #1;
    chk("drain_done_tok", 32'(bus.TokOut), 32'd0);
    chk("drain_done_en", 32'(bus.EnOut), 32'd0);
    chk("drain_done_addr", 32'(bus.LeAddr), 32'h01);

    // Mask flushes triggered cells and blocks writes without counting overflow.
    do_reset();
    write_hit(16'h0055, 9'd1); next_cyc();
    write_hit(16'h0066, 9'd0); next_cyc();
    idle_inputs();
    bus.L1 = 1'b1; bus.L1Tag = 5'd3; next_cyc();
    idle_inputs();
    #1;
    chk("mask_pre_en", 32'(bus.EnOut), 32'd1);
    chk("mask_pre_tot", 32'(bus.ReadTot), 32'h0055);
    bus.PixOffCnfg = 1'b1; bus.LE = 1'b1; bus.HitTot = 16'h0005;
    #1;
    chk("mask_tok", 32'(bus.TokOut), 32'd0);
    chk("mask_en", 32'(bus.EnOut), 32'd0);
    chk("mask_addr", 32'(bus.LeAddr), 32'h00);
    chk("mask_tot", 32'(bus.ReadTot), 32'h0);
    bus.TokIn = 1'b1;
    #1;
    chk("mask_tok_pass", 32'(bus.TokOut), 32'd1);
    next_cyc();
    idle_inputs();
    #1;
    chk("unmask_en", 32'(bus.EnOut), 32'd0);
    chk("unmask_tok", 32'(bus.TokOut), 32'd0);
    chk("unmask_addr", 32'(bus.LeAddr), 32'h01);
    chk("unmask_full", 32'(bus.Full), 32'd0);
    chk("unmask_ovf", 32'(bus.OverflowCnt), 32'd0);

    // Asynchronous reset mid-readout with four cells occupied.
    do_reset();
    write_hit(16'h0111, 9'd0); next_cyc();
    write_hit(16'h0AAA, 9'd20); bus.L1 = 1'b1; bus.L1Tag = 5'd4; next_cyc();
    bus.L1 = 1'b0; write_hit(16'h0BBB, 9'd20); next_cyc();
    write_hit(16'h0CCC, 9'd20); next_cyc();
    idle_inputs();
    #1;
    chk("pre_arst_en", 32'(bus.EnOut), 32'd1);
    chk("pre_arst_tot", 32'(bus.ReadTot), 32'h0111);
    chk("pre_arst_tag", 32'(bus.ReadTag), 32'd4);
    chk("pre_arst_addr", 32'(bus.LeAddr), 32'h10);
    #1;
    Reset = 1'b1;
    #1;
    chk("arst_en", 32'(bus.EnOut), 32'd0);
    chk("arst_tot", 32'(bus.ReadTot), 32'h0);
    chk("arst_tag", 32'(bus.ReadTag), 32'd0);
    chk("arst_full", 32'(bus.Full), 32'd0);
    chk("arst_addr", 32'(bus.LeAddr), 32'h01);
    chk("arst_ovf", 32'(bus.OverflowCnt), 32'd0);
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_region_latency_buffer.md
Name: pixel_region_latency_buffer

Overview:
- Parametrised next-generation pixel-region hit buffer.
- Stores ToT hits from a pixel region in a MEM_DEPTH-deep bank of cells; each cell runs its own latency countdown.
- At expiry a cell is kept only if an L1 trigger arrives in that cycle, and is tagged with the trigger ID.
- Triggered cells drain one per cycle through the column token chain, with a drop counter for overflow.

Parameters:
- MEM_DEPTH, 8, number of latency cells (2..32).
- NPIX, 4, pixels per region.
- TOT_W, 4, ToT bits per pixel.
- LAT_W, 9, latency counter width.
- TAG_W, 5, trigger tag width.
- OVF_W, 8, overflow counter width.

Ports:
- Clk  in  1  region clock.
- Reset  in  1  asynchronous, active-high reset.
- LE  in  1  hit leading-edge strobe; HitTot valid this cycle.
- HitTot  in  NPIX*TOT_W  per-pixel ToT; pixel p in bits [p*TOT_W +: TOT_W]; 0 = no hit.
- L1  in  1  trigger strobe.
- L1Tag  in  TAG_W  tag accompanying L1.
- LatCnfg  in  LAT_W  latency setting.
- PixOffCnfg  in  1  region mask.
- TokIn  in  1  token from upstream region.
- TokOut  out  1  token to downstream region.
- ReadData  in  1  readout acknowledge; pops the presented cell.
- EnOut  out  1  this region is driving the read bus.
- ReadTot  out  NPIX*TOT_W  ToT of the presented cell.
- ReadTag  out  TAG_W  tag of the presented cell.
- LeAddr  out  MEM_DEPTH  one-hot write pointer.
- Full  out  1  all cells occupied.
- OverflowCnt  out  OVF_W  saturating count of dropped hits.

Behaviour:
- Cell state machine, per cell: FREE -> WAIT -> TRIG -> FREE. Each cell holds state, a LAT_W counter, ToT and tag.
- Write:
  - A write occurs on the edge where LE=1, HitTot!=0, PixOffCnfg=0 and at least one cell is FREE.
  - The lowest-index FREE cell (as of before the edge) captures HitTot, loads its counter with LatCnfg, and enters WAIT.
  - LatCnfg is latched per cell; changing it only affects later writes.
- WAIT:
  - Each edge with counter>0: counter decrements.
  - On the edge where counter==0 and L1=1: cell -> TRIG and captures L1Tag.
  - On the edge where counter==0 and L1=0: cell -> FREE and the data is discarded.
  - Net effect: L1 must be sampled exactly LatCnfg+1 edges after the LE edge. LatCnfg=0 means the next edge.
  - Several cells may expire on the same edge; all of them take the same L1/L1Tag.
- Read path (combinational outputs):
  - ready_any = any cell in TRIG.
  - sel = lowest-index cell in TRIG.
  - TokOut = TokIn | (ready_any & ~PixOffCnfg).
  - EnOut = ~TokIn & ready_any & ~PixOffCnfg.
  - ReadTot/ReadTag = data of cell sel when EnOut=1, otherwise 0.
  - On an edge with EnOut=1 and ReadData=1: cell sel -> FREE. At most one cell is freed per edge.
  - ReadData while EnOut=0 has no effect.
- Mask: PixOffCnfg=1 blocks writes (no overflow counted); all TRIG cells -> FREE on the next edge; WAIT cells continue counting. TokOut then equals TokIn.
- LeAddr / Full:
  - LeAddr = one-hot lowest FREE cell; all-zero when every cell is occupied or PixOffCnfg=1.
  - Full = no cell FREE.
- Overflow: on an edge with LE=1, HitTot!=0, PixOffCnfg=0 and Full=1, OverflowCnt increments, saturating at 2^OVF_W-1.
- Simultaneous events:
  - A cell freed on edge E (read, expiry or mask) is not writable until edge E+1. The write pointer uses pre-edge state.
  - A write and a read on the same edge both take effect.
- Reset (asynchronous, applies immediately, including mid-readout):
  - All cells FREE, counters/ToT/tags 0, OverflowCnt=0.
  - Resulting outputs: EnOut=0, ReadTot=0, ReadTag=0, Full=0, TokOut=TokIn, LeAddr=1 (all-zero if PixOffCnfg=1).
  - Sequential state resumes on the first edge after Reset deasserts.
- Latency: a hit is visible on EnOut LatCnfg+1 edges after LE, combinationally in the cycle after the trigger edge.

Test Plan:
- LatCnfg=10; LE with HitTot=0x1234; L1=1 with L1Tag=7 exactly 11 edges later -> next cycle EnOut=1, ReadTot=0x1234, ReadTag=7; ReadData=1 -> cell freed, EnOut=0, LeAddr=1.
- Same LE but L1 arrives 10 or 12 edges later -> EnOut never asserts; cell 0 returns to FREE after the 11th edge.
- MEM_DEPTH=8; 10 consecutive LE with nonzero ToT and no L1 -> Full=1 after 8 writes, OverflowCnt=2, LeAddr=0. Let the counters expire -> Full=0, LeAddr=1.
- Three hits triggered on the same edge; TokIn=1 for 5 cycles -> EnOut=0, TokOut=1. TokIn=0 with ReadData=1 -> cells drain in order 0,1,2 over 3 cycles, then TokOut=0.
- Two TRIG cells present; PixOffCnfg=1 -> next edge both cells FREE, TokOut=TokIn, LE ignored with OverflowCnt unchanged.
- Assert Reset while EnOut=1 with 4 cells occupied -> EnOut=0, Full=0, OverflowCnt=0, LeAddr=1 immediately (asynchronously), with no clock edge.
